ram_copy_engine: RTL and testbench

- Initiator-side block for the single-port data RAM: it drives the RAM's r, w, address and mem_in pins and samples mem_out.
- Executes one block command at a time: copy N words from src to dst (read-then-write per word), or fill N words at dst with a constant.
- Sits between the control/CPU side (start/busy/done handshake) and the RAM. It is the RAM's only master while busy.

---
 rtl/ram_copy_pkg.sv | 16 +
 rtl/ram_copy_addr_gen.sv | 48 ++++
 rtl/ram_copy_engine.sv | 145 ++++++++++++++
 tb/tb_ram_copy_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_copy_pkg.sv
// Shared types and constants for the RAM block copy/fill engine.
package ram_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

  localparam logic MODE_COPY  = 1'b0;
  localparam logic MODE_FILL  = 1'b1;
  localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/ram_copy_addr_gen.sv
// Source/destination word pointers plus written-word counter for one block command.
// Load on accept; src steps after each read, dst and count step after each write.
module ram_copy_addr_gen
  import ram_copy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              src_step,
  input  logic              dst_step,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [LEN_W-1:0]  count,
  output logic              last
);

  logic [LEN_W-1:0] len_q;

  // Pointers wrap naturally modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      len_q   <= '0;
    end else if (load) begin
      src_ptr <= src_addr;
      dst_ptr <= dst_addr;
      count   <= '0;
      len_q   <= len;
    end else begin
      if (src_step) src_ptr <= src_ptr + ADDR_W'(WORD_BYTES);
      if (dst_step) begin
        dst_ptr <= dst_ptr + ADDR_W'(WORD_BYTES);
        count   <= count + LEN_W'(1);
      end
    end
  end

  assign last = ((count + LEN_W'(1)) == len_q);

endmodule

// File: rtl/ram_copy_engine.sv
// Single-port RAM master: copies or fills a block of words, one command at a time.
// COPY costs 2+READ_LATENCY cycles/word, FILL 1 cycle/word; start is ignored while busy.
module ram_copy_engine
  import ram_copy_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  output logic              r,
  output logic              w,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t            state, state_nxt;
  logic              mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic [WCW-1:0]    wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] mem_in_q;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic              last;
  logic              accept, misaligned, wait_last;

  assign accept     = (state == IDLE) && start;
  assign misaligned = (dst_addr[1:0] != 2'b00) ||
                      ((mode == MODE_COPY) && (src_addr[1:0] != 2'b00));
  assign wait_last  = (wait_cnt == WCW'(READ_LATENCY - 1));

  ram_copy_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .src_step (state == READ),
    .dst_step (state == WRITE),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .count    (words_done),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !misaligned) begin
          if (len == '0)              state_nxt = DONE;
          else if (mode == MODE_FILL) state_nxt = WRITE;
          else                        state_nxt = READ;
        end
      end
      READ:  state_nxt = WAIT;
      WAIT:  if (wait_last) state_nxt = WRITE;
      WRITE: begin
        if (last)                    state_nxt = DONE;
        else if (mode_q == MODE_FILL) state_nxt = WRITE;
        else                         state_nxt = READ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latches, read-data capture and hold registers for the RAM pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q   <= MODE_COPY;
      fill_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      addr_q   <= '0;
      mem_in_q <= '0;
    end else begin
      err_q <= accept && misaligned;
      if (accept) begin
        mode_q <= mode;
        fill_q <= fill_value;
      end
      if (state == READ)      wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + WCW'(1);
      if ((state == WAIT) && wait_last) data_q <= mem_out;
      addr_q   <= address;
      mem_in_q <= mem_in;
    end
  end

  always_comb begin
    r       = 1'b0;
    w       = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    address = addr_q;
    mem_in  = mem_in_q;
    case (state)
      READ: begin
        r       = 1'b1;
        busy    = 1'b1;
        address = src_ptr;
      end
      WAIT: busy = 1'b1;
      WRITE: begin
        w       = 1'b1;
        busy    = 1'b1;
        address = dst_ptr;
        mem_in  = (mode_q == MODE_FILL) ? fill_q : data_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: RAM model plus scoreboards of expected reads and writes.
module tb_ram_copy_engine;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int RL     = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] fill_value = '0;
  logic              busy, done, err, r, w;
  logic [LEN_W-1:0]  words_done;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_out = '0;

  always #5 clk = ~clk;

  ram_copy_engine #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .LEN_W        (LEN_W),
    .READ_LATENCY (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .r          (r),
    .w          (w),
    .address    (address),
    .mem_in     (mem_in),
    .mem_out    (mem_out)
  );

  logic [31:0] ram [logic [31:0]];

  always @(posedge clk) begin
    if (w === 1'b1) ram[address] = mem_in;
    if (r === 1'b1) mem_out <= ram.exists(address) ? ram[address] : 32'h0;
  end

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int err_cnt = 0;
  logic [63:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [63:0] e_wr;
  logic [31:0] e_rd;

  // Scoreboard: every RAM access is checked against the expected queues.
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (r === 1'b1 || w === 1'b1) begin
      acc_cnt++;
      tests++;
      if (r === 1'b1 && w === 1'b1) begin
        fails++;
        $display("FAIL rw_exclusive: r=%b w=%b both high, required not both", r, w);
      end
    end
    if (w === 1'b1) begin
      tests++;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL write_sb: unexpected write addr=%h data=%h, required none", address, mem_in);
      end else begin
        e_wr = exp_wr.pop_front();
        if ({address, mem_in} !== e_wr)
          begin fails++; $display("FAIL write_sb: got addr=%h data=%h, required addr=%h data=%h",
                                   address, mem_in, e_wr[63:32], e_wr[31:0]); end
      end
    end
    if (r === 1'b1) begin
      tests++;
      if (exp_rd.size() == 0) begin
        fails++;
        $display("FAIL read_sb: unexpected read addr=%h, required none", address);
      end else begin
        e_rd = exp_rd.pop_front();
        if (address !== e_rd)
          begin fails++; $display("FAIL read_sb: got addr=%h, required %h", address, e_rd); end
      end
    end
  end

  task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] l, input logic [31:0] f);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_value = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({r, w, busy, done, err} !== 5'b0)
      begin fails++; $display("FAIL reset_ctrl: r,w,busy,done,err=%b, required 00000", {r, w, busy, done, err}); end
    tests++;
    if (address !== 32'h0 || mem_in !== 32'h0 || words_done !== 16'h0)
      begin fails++; $display("FAIL reset_data: addr=%h mem_in=%h wd=%0d, required all 0", address, mem_in, words_done); end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_fill;
    int c, a0;
    a0 = acc_cnt;
    exp_wr.push_back({32'h1000, 32'h13FF});
    exp_wr.push_back({32'h1004, 32'h13FF});
    issue(1'b1, 32'h0, 32'h1000, 16'd2, 32'h13FF);
    wait_done(c);
    tests++;
    if (c !== 3) begin fails++; $display("FAIL fill_latency: got %0d, required 3", c); end
    tests++;
    if (words_done !== 16'd2) begin fails++; $display("FAIL fill_words_done: got %0d, required 2", words_done); end
    tests++;
    if (exp_wr.size() != 0 || acc_cnt - a0 != 2)
      begin fails++; $display("FAIL fill_accesses: left=%0d acc=%0d, required 0 and 2", exp_wr.size(), acc_cnt - a0); end
  endtask

  task automatic test_copy;
    int c;
    ram[32'h1000] = 32'h13FF;
    ram[32'h1004] = 32'h100;
    exp_rd.push_back(32'h1000);
    exp_rd.push_back(32'h1004);
    exp_wr.push_back({32'h2000, 32'h13FF});
    exp_wr.push_back({32'h2004, 32'h100});
    issue(1'b0, 32'h1000, 32'h2000, 16'd2, 32'hDEAD);
    wait_done(c);
    tests++;
    if (c !== 7) begin fails++; $display("FAIL copy_latency: got %0d, required 7", c); end
    tests++;
    if (words_done !== 16'd2 || exp_wr.size() != 0 || exp_rd.size() != 0)
      begin fails++; $display("FAIL copy_complete: wd=%0d wr_left=%0d rd_left=%0d, required 2,0,0",
                              words_done, exp_wr.size(), exp_rd.size()); end
  endtask

  task automatic test_overlap;
    int c;
    ram[32'h5000] = 32'hCAFE0001;
    exp_rd.push_back(32'h5000);
    exp_rd.push_back(32'h5004);
    exp_rd.push_back(32'h5008);
    exp_wr.push_back({32'h5004, 32'hCAFE0001});
    exp_wr.push_back({32'h5008, 32'hCAFE0001});
    exp_wr.push_back({32'h500C, 32'hCAFE0001});
    issue(1'b0, 32'h5000, 32'h5004, 16'd3, 32'h0);
    wait_done(c);
    tests++;
    if (c !== 10) begin fails++; $display("FAIL overlap_latency: got %0d, required 10", c); end
    tests++;
    if (ram[32'h500C] !== 32'hCAFE0001)
      begin fails++; $display("FAIL overlap_data: got %h, required cafe0001", ram[32'h500C]); end
  endtask

  task automatic test_err;
    int a0, e0;
    a0 = acc_cnt;
    e0 = err_cnt;
    issue(1'b1, 32'h0, 32'h1002, 16'd2, 32'h1);
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL err_dst: err=%b busy=%b, required 1 0", err, busy); end
    issue(1'b0, 32'h1001, 32'h2000, 16'd2, 32'h1);
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL err_src: err=%b busy=%b, required 1 0", err, busy); end
    repeat (3) @(negedge clk);
    tests++;
    if (err_cnt - e0 != 2) begin fails++; $display("FAIL err_pulses: got %0d, required 2", err_cnt - e0); end
    issue(1'b1, 32'h0, 32'h6000, 16'd0, 32'h1);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || words_done !== 16'd0)
      begin fails++; $display("FAIL len0_done: done=%b busy=%b wd=%0d, required 1 0 0", done, busy, words_done); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || acc_cnt != a0)
      begin fails++; $display("FAIL len0_quiet: done=%b accesses=%0d, required 0 and 0", done, acc_cnt - a0); end
  endtask

  task automatic test_busy_ignore;
    int c;
    for (int i = 0; i < 4; i++) exp_wr.push_back({32'h1000 + 32'(4 * i), 32'hAA55});
    issue(1'b1, 32'h0, 32'h1000, 16'd4, 32'hAA55);
    mode = 1'b1; dst_addr = 32'h3000; len = 16'd1; fill_value = 32'h3333; start = 1'b1;
    wait_done(c);
    start = 1'b0;
    tests++;
    if (c !== 5) begin fails++; $display("FAIL busy_latency: got %0d, required 5", c); end
    repeat (3) @(negedge clk);
    tests++;
    if (words_done !== 16'd4 || busy !== 1'b0 || exp_wr.size() != 0)
      begin fails++; $display("FAIL busy_ignore: wd=%0d busy=%b left=%0d, required 4 0 0", words_done, busy, exp_wr.size()); end
  endtask

  task automatic test_reset_mid;
    int c, dcnt;
    exp_wr.push_back({32'h7000, 32'h77});
    exp_wr.push_back({32'h7004, 32'h77});
    issue(1'b1, 32'h0, 32'h7000, 16'd4, 32'h77);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({r, w, busy, done} !== 4'b0)
      begin fails++; $display("FAIL reset_mid: r,w,busy,done=%b, required 0000", {r, w, busy, done}); end
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1 || w === 1'b1) dcnt++;
    end
    tests++;
    if (dcnt != 0 || exp_wr.size() != 0)
      begin fails++; $display("FAIL reset_mid_quiet: done/w=%0d left=%0d, required 0 0", dcnt, exp_wr.size()); end
    exp_wr.push_back({32'h7100, 32'h1});
    issue(1'b1, 32'h0, 32'h7100, 16'd1, 32'h1);
    wait_done(c);
    tests++;
    if (c !== 2 || words_done !== 16'd1)
      begin fails++; $display("FAIL reset_fresh: lat=%0d wd=%0d, required 2 1", c, words_done); end
  endtask

  task automatic test_wrap;
    int c, e0;
    e0 = err_cnt;
    exp_wr.push_back({32'hFFFFFFFC, 32'h5A});
    exp_wr.push_back({32'h00000000, 32'h5A});
    issue(1'b1, 32'h0, 32'hFFFFFFFC, 16'd2, 32'h5A);
    wait_done(c);
    tests++;
    if (c !== 3 || err_cnt != e0 || exp_wr.size() != 0)
      begin fails++; $display("FAIL wrap: lat=%0d errs=%0d left=%0d, required 3 0 0", c, err_cnt - e0, exp_wr.size()); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_copy;
    test_overlap;
    test_err;
    test_busy_ignore;
    test_reset_mid;
    test_wrap;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
